// File: rtl/sr_pulse_conditioner_pkg.sv
// Shared defaults and the arbitration result encoding for the SR pulse conditioner.
package sr_cond_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int CNT_W_DEF           = 5;

  typedef enum logic [1:0] {
    ARB_NONE     = 2'd0,
    ARB_SET      = 2'd1,
    ARB_RST      = 2'd2,
    ARB_CONFLICT = 2'd3
  } arb_t;

endpackage

// File: rtl/sr_pulse_conditioner_debounce_channel.sv
// One button channel: synchroniser, saturating debounce counter, stable level and rise detect.
module debounce_channel
  import sr_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_next;
  logic                   stable_reg;
  logic                   stable_next;
  logic                   prev_reg;
  logic                   sampled;

  assign sampled = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn};
    end
  end

  // The count stops at its terminal value, so a long disagreement can never wrap it.
  always_comb begin
    cnt_next    = '0;
    stable_next = stable_reg;
    if (sampled != stable_reg) begin
      if (cnt_reg >= CNT_LAST) begin
        stable_next = sampled;
        cnt_next    = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
      prev_reg   <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      stable_reg <= stable_next;
      prev_reg   <= stable_reg;
    end
  end

  assign level = stable_reg;
  assign rise  = stable_reg & ~prev_reg;

endmodule

// File: rtl/sr_pulse_conditioner.sv
// Debounces set/reset buttons and turns debounced rises into mutually exclusive one-cycle S/R pulses.
module sr_pulse_conditioner
  import sr_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn_i,
  input  logic rst_btn_i,
  output logic s_o,
  output logic r_o,
  output logic set_level_o,
  output logic rst_level_o,
  output logic conflict_o
);

  // Channel 0 is the set request, channel 1 the reset request.
  logic [1:0] btn;
  logic [1:0] level;
  logic [1:0] rise;
  arb_t       arb;

  assign btn = {rst_btn_i, set_btn_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_chan (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn[gi]),
        .level(level[gi]),
        .rise (rise[gi])
      );
    end
  endgenerate

  // A rise that meets an already-high opposite level is refused rather than forming S=R=1.
  always_comb begin
    arb = ARB_NONE;
    if (rise[0] && rise[1]) begin
      arb = ARB_CONFLICT;
    end else if (rise[0]) begin
      arb = level[1] ? ARB_CONFLICT : ARB_SET;
    end else if (rise[1]) begin
      arb = level[0] ? ARB_CONFLICT : ARB_RST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_o        <= 1'b0;
      r_o        <= 1'b0;
      conflict_o <= 1'b0;
    end else begin
      s_o        <= (arb == ARB_SET);
      r_o        <= (arb == ARB_RST);
      conflict_o <= (arb == ARB_CONFLICT);
    end
  end

  assign set_level_o = level[0];
  assign rst_level_o = level[1];

endmodule
